// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Key index is col*4 + row; KEY_CODE turns that index into the key's label code.
package keypad_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } kp_state_e;

  localparam logic [3:0] CODE_IDLE = 4'h0;
  localparam logic [3:0] CODE_A    = 4'hA;
  localparam logic [3:0] CODE_B    = 4'hB;
  localparam logic [3:0] CODE_C    = 4'hC;
  localparam logic [3:0] CODE_D    = 4'hD;

  // Physical layout (rows x cols): 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
  // Within each group of four, the entries are rows 0..3 of one column.
  localparam logic [3:0] KEY_CODE [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    CODE_A, CODE_B, CODE_C, CODE_D
  };

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } cand_t;

  localparam cand_t CAND_NONE = '{vld: 1'b0, idx: 4'h0};

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_async;
    sync_d = meta_q;
  end

  // Reset to all-high so that no key appears pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sampling, scan debounce and key commit.
// Optional KEYPAD_MULTI_REJECT_EN: scans that see two or more keys are discarded.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_CYCLES     = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] decode,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int SLOT_W = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
  localparam int STB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(COL_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(DEBOUNCE_SCANS);

  logic [3:0]        row_s;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_q, col_d;
  cand_t             acc_q, acc_d;
  cand_t             prev_q, prev_d;
  logic [STB_W-1:0]  stable_cnt_q, stable_cnt_d;

  logic       sample, end_scan, commit;
  logic [3:0] pressed;
  logic [1:0] first_row;
  cand_t      col_cand, scan_cand;
  logic [3:0] scan_code;

  kp_state_e  state_q;
  logic [3:0] decode_q;
  logic       key_valid_q, key_strobe_q;

`ifdef KEYPAD_MULTI_REJECT_EN
  logic [1:0] keys_q, keys_d;
  logic [2:0] col_keys, tot_keys;
`endif

  keypad_row_sync u_row_sync (
    .clk      (clk),
    .rst      (rst),
    .row_async(row),
    .row_sync (row_s)
  );

  always_comb begin
    sample   = (slot_cnt_q == SLOT_LAST);
    end_scan = sample && (col_idx_q == 2'd3);

    if (sample) begin
      slot_cnt_d = '0;
      col_idx_d  = col_idx_q + 2'd1;
    end else begin
      slot_cnt_d = slot_cnt_q + SLOT_W'(1);
      col_idx_d  = col_idx_q;
    end
    col_d = ~(4'b0001 << col_idx_d);

    // Lowest row wins inside a column; earlier columns already sit in acc_q.
    pressed   = ~row_s;
    first_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) first_row = 2'(r);
    end
    col_cand  = '{vld: |pressed, idx: {col_idx_q, first_row}};
    scan_cand = acc_q.vld ? acc_q : col_cand;
    scan_code = KEY_CODE[scan_cand.idx];

    acc_d = acc_q;
    if (sample) acc_d = end_scan ? CAND_NONE : scan_cand;

`ifdef KEYPAD_MULTI_REJECT_EN
    col_keys = {2'b00, pressed[0]} + {2'b00, pressed[1]}
             + {2'b00, pressed[2]} + {2'b00, pressed[3]};
    tot_keys = {1'b0, keys_q} + col_keys;
    keys_d   = keys_q;
    if (sample) begin
      if (end_scan)               keys_d = 2'd0;
      else if (tot_keys >= 3'd2)  keys_d = 2'd2;
      else                        keys_d = tot_keys[1:0];
    end
`endif

    stable_cnt_d = stable_cnt_q;
    prev_d       = prev_q;
    commit       = 1'b0;
    if (end_scan) begin
`ifdef KEYPAD_MULTI_REJECT_EN
      if (tot_keys >= 3'd2) begin
        stable_cnt_d = '0;
        prev_d       = CAND_NONE;
      end else begin
`else
      begin
`endif
        if (scan_cand == prev_q)
          stable_cnt_d = (stable_cnt_q == STB_MAX) ? stable_cnt_q : stable_cnt_q + STB_W'(1);
        else
          stable_cnt_d = STB_W'(1);
        prev_d = scan_cand;
        commit = (stable_cnt_d == STB_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      col_idx_q    <= 2'd0;
      col_q        <= 4'b1110;
      acc_q        <= CAND_NONE;
      prev_q       <= CAND_NONE;
      stable_cnt_q <= '0;
`ifdef KEYPAD_MULTI_REJECT_EN
      keys_q       <= 2'd0;
`endif
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      acc_q        <= acc_d;
      prev_q       <= prev_d;
      stable_cnt_q <= stable_cnt_d;
`ifdef KEYPAD_MULTI_REJECT_EN
      keys_q       <= keys_d;
`endif
    end
  end

  // Commit FSM: the saturated stable count keeps commit high, so only changes act.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RELEASED;
      decode_q     <= CODE_IDLE;
      key_valid_q  <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      key_strobe_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (commit && scan_cand.vld) begin
            state_q      <= PRESSED;
            decode_q     <= scan_code;
            key_valid_q  <= 1'b1;
            key_strobe_q <= 1'b1;
          end
        end
        PRESSED: begin
          if (commit) begin
            if (!scan_cand.vld) begin
              state_q     <= RELEASED;
              decode_q    <= CODE_IDLE;
              key_valid_q <= 1'b0;
            end else if (scan_code != decode_q) begin
              decode_q     <= scan_code;
              key_strobe_q <= 1'b1;
            end
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  assign col        = col_q;
  assign decode     = decode_q;
  assign key_valid  = key_valid_q;
  assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

  localparam int K_1 = 0;
  localparam int K_4 = 1;
  localparam int K_3 = 8;
  localparam int K_A = 12;
  localparam int K_B = 13;
  localparam int K_C = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] decode;
  logic       key_valid;
  logic       key_strobe;
  logic [15:0] held = '0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  keypad_scanner #(.COL_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .decode    (decode),
    .key_valid (key_valid),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // A held key pulls its row low only while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (held[c*4+r]) row[r] = 1'b0;
  end

  task automatic align_scan();
    logic [3:0] last;
    logic       found;
    last  = col;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && last == 4'b0111) found = 1'b1;
      last = col;
    end
    total_cnt++;
    if (!found) $display("FAIL align_scan: scan start not seen, col=%b required wrap 0111->1110", col);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({col, decode, key_valid, key_strobe} !== {4'b1110, 4'h0, 1'b0, 1'b0})
      $display("FAIL reset_values: col=%b decode=%h valid=%b strobe=%b required 1110 0 0 0",
               col, decode, key_valid, key_strobe);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (col !== 4'b1110) $display("FAIL reset_col_hold: col=%b required 1110", col);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (col !== 4'b1101) $display("FAIL reset_col_rotate: col=%b required 1101", col);
    else pass_cnt++;
    total_cnt++;
    if (decode !== 4'h0 || key_valid !== 1'b0)
      $display("FAIL reset_idle: decode=%h valid=%b required 0 0", decode, key_valid);
    else pass_cnt++;
  endtask

  task automatic test_hold_key3();
    int strobes = 0;
    int first = -1;
    align_scan();
    held = '0;
    held[K_3] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (key_strobe) begin
        strobes++;
        if (first < 0) first = i + 1;
      end
    end
    total_cnt++;
    if (strobes !== 1) $display("FAIL key3_strobes: got %0d required 1", strobes);
    else pass_cnt++;
    total_cnt++;
    if (first < 1 || first > 50) $display("FAIL key3_latency: got %0d cycles required 1..50", first);
    else pass_cnt++;
    total_cnt++;
    if (decode !== 4'h3 || key_valid !== 1'b1)
      $display("FAIL key3_commit: decode=%h valid=%b required 3 1", decode, key_valid);
    else pass_cnt++;
  endtask

  task automatic test_release();
    int strobes = 0;
    int gone = -1;
    logic valid_after_one = 1'b0;
    align_scan();
    held = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (key_strobe) strobes++;
      if (i == 15) valid_after_one = key_valid;
      if (!key_valid && gone < 0) gone = i + 1;
    end
    total_cnt++;
    if (valid_after_one !== 1'b1)
      $display("FAIL release_debounce: valid after one empty scan=%b required 1", valid_after_one);
    else pass_cnt++;
    total_cnt++;
    if (gone < 0) $display("FAIL release_timeout: key_valid still 1 after 50 cycles, required 0");
    else pass_cnt++;
    total_cnt++;
    if (decode !== 4'h0 || key_valid !== 1'b0 || strobes !== 0)
      $display("FAIL release_state: decode=%h valid=%b strobes=%0d required 0 0 0",
               decode, key_valid, strobes);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int strobes = 0;
    int valid_seen = 0;
    align_scan();
    for (int rep = 0; rep < 4; rep++) begin
      held = '0;
      held[K_A] = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (key_strobe) strobes++;
        if (key_valid) valid_seen++;
      end
      held = '0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (key_strobe) strobes++;
        if (key_valid) valid_seen++;
      end
    end
    total_cnt++;
    if (strobes !== 0 || valid_seen !== 0)
      $display("FAIL bounce_no_commit: strobes=%0d valid_cycles=%0d required 0 0", strobes, valid_seen);
    else pass_cnt++;
    total_cnt++;
    if (decode !== 4'h0) $display("FAIL bounce_decode: decode=%h required 0", decode);
    else pass_cnt++;
  endtask

  task automatic test_direct_change();
    int strobes = 0;
    int dropped = 0;
    logic [3:0] mid_code;
    align_scan();
    held = '0;
    held[K_B] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (key_strobe) strobes++;
    end
    mid_code = decode;
    held = '0;
    held[K_C] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (key_strobe) strobes++;
      if (decode == 4'h0 || !key_valid) dropped++;
    end
    total_cnt++;
    if (mid_code !== 4'hB) $display("FAIL change_first: decode=%h required B", mid_code);
    else pass_cnt++;
    total_cnt++;
    if (strobes !== 2) $display("FAIL change_strobes: got %0d required 2", strobes);
    else pass_cnt++;
    total_cnt++;
    if (dropped !== 0) $display("FAIL change_no_gap: idle cycles=%0d required 0", dropped);
    else pass_cnt++;
    total_cnt++;
    if (decode !== 4'hC || key_valid !== 1'b1)
      $display("FAIL change_second: decode=%h valid=%b required C 1", decode, key_valid);
    else pass_cnt++;
    held = '0;
    repeat (48) @(negedge clk);
    total_cnt++;
    if (key_valid !== 1'b0) $display("FAIL change_release: valid=%b required 0", key_valid);
    else pass_cnt++;
  endtask

  task automatic test_multi();
    int strobes = 0;
    logic [3:0] exp_code;
    logic       exp_valid;
    int         exp_strobes;
`ifdef KEYPAD_MULTI_REJECT_EN
    exp_code = 4'h0; exp_valid = 1'b0; exp_strobes = 0;
`else
    exp_code = 4'h1; exp_valid = 1'b1; exp_strobes = 1;
`endif
    align_scan();
    held = '0;
    held[K_1] = 1'b1;
    held[K_4] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (key_strobe) strobes++;
    end
    total_cnt++;
    if (decode !== exp_code || key_valid !== exp_valid)
      $display("FAIL multi_decode: decode=%h valid=%b required %h %b", decode, key_valid, exp_code, exp_valid);
    else pass_cnt++;
    total_cnt++;
    if (strobes !== exp_strobes) $display("FAIL multi_strobes: got %0d required %0d", strobes, exp_strobes);
    else pass_cnt++;
    held = '0;
    repeat (48) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    align_scan();
    held = '0;
    held[K_3] = 1'b1;
    repeat (53) @(negedge clk);
    total_cnt++;
    if (decode !== 4'h3) $display("FAIL midrst_pre: decode=%h required 3", decode);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({col, decode, key_valid} !== {4'b1110, 4'h0, 1'b0})
      $display("FAIL midrst_clear: col=%b decode=%h valid=%b required 1110 0 0", col, decode, key_valid);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      if (key_strobe) strobes++;
    end
    total_cnt++;
    if (strobes !== 1 || decode !== 4'h3 || key_valid !== 1'b1)
      $display("FAIL midrst_recommit: strobes=%0d decode=%h valid=%b required 1 3 1",
               strobes, decode, key_valid);
    else pass_cnt++;
    held = '0;
  endtask

  initial begin
    test_reset();
    test_hold_key3();
    test_release();
    test_bounce();
    test_direct_change();
    test_multi();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
